mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one physical memory port between the instruction-fetch requester (port A, read-only) and the data/memory-stage requester (port B, read/write).
- Sits between the pipeline's fetch/memory stages and physical memory.
- Serialises requests, latches the winning command, and routes the response back to the owner.
- Ties are resolved round-robin, so neither stage starves.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, data word width.
- MASK_WIDTH, DATA_WIDTH/8, byte-enable width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- read_a  in  1  port A read request, held until resp_a
- address_a  in  ADDR_WIDTH  port A address
- resp_a  out  1  port A completion pulse, one cycle
- rdata_a  out  DATA_WIDTH  port A read data, valid with resp_a
- read_b  in  1  port B read request, held until resp_b
- write_b  in  1  port B write request, held until resp_b
- address_b  in  ADDR_WIDTH  port B address
- wdata_b  in  DATA_WIDTH  port B write data
- wmask_b  in  MASK_WIDTH  port B byte enables
- resp_b  out  1  port B completion pulse, one cycle
- rdata_b  out  DATA_WIDTH  port B read data, valid with resp_b
- pmem_read  out  1  memory read command
- pmem_write  out  1  memory write command
- pmem_address  out  ADDR_WIDTH  memory address
- pmem_wdata  out  DATA_WIDTH  memory write data
- pmem_wmask  out  MASK_WIDTH  memory byte enables
- pmem_rdata  in  DATA_WIDTH  memory read data
- pmem_resp  in  1  memory completion, one cycle
- busy  out  1  high while a transaction is outstanding

Behaviour:
- FSM states: IDLE, SERVE_A, SERVE_B. Plus a last_grant flag (A or B).
- Reset (rst_n low, asynchronous):
  - state = IDLE, last_grant = A.
  - Latched command registers all zero.
  - pmem_read, pmem_write, resp_a, resp_b, busy = 0.
  - rdata_a, rdata_b = 0.
- IDLE arbitration:
  - req_a = read_a; req_b = read_b | write_b.
  - Only one request pending: grant it.
  - Both pending: grant the port that is not last_grant. The first tie after reset therefore goes to B.
- Grant edge:
  - Capture address, wdata, wmask and the rd/wr type into command registers.
  - Set last_grant to the granted port; move to SERVE_x.
- Command drive:
  - pmem_* outputs are driven only from the command registers.
  - Command is visible the cycle after the request is first seen in IDLE (1-cycle grant latency).
  - Port A always issues a read with wmask = 0.
  - read_b and write_b both high: treated as a write.
- SERVE_x:
  - Hold pmem_read or pmem_write steady until pmem_resp.
  - In the pmem_resp cycle: resp_x = 1 (combinational), rdata_x = pmem_rdata, the other port's resp = 0.
- Completion edge:
  - The other port pending: grant it directly, with no IDLE bubble. Capture its command; pmem command re-asserts the next cycle.
  - Same port still asserting: that is a new request; arbitrate as in IDLE with last_grant updated.
  - Nothing pending: go to IDLE.
- Completed transaction's pmem_read/pmem_write deassert in the cycle after pmem_resp, unless a back-to-back grant occurs.
- Requester drops its request mid-transaction: no abort. The latched command runs to completion and resp_x still pulses; the requester ignores it.
- pmem_resp in IDLE, or after reset mid-transaction: ignored, no resp_x generated.
- rdata_a / rdata_b outside their resp cycle: hold the last captured value. This value is not guaranteed.
- busy = (state != IDLE).
- Back-to-back operation: at most one transaction outstanding; throughput is one transaction per memory latency.

Decomposition:
- rv32i_types package (shared): arb_state_t enum (IDLE, SERVE_A, SERVE_B); arb_port_t (PORT_A, PORT_B); mem_cmd_t struct (addr, wdata, wmask, write).
- One natural sub-module, arb_cmd_reg: the command-capture register with load, which the top instantiates once.
- FSM and round-robin logic stay in mem_arbiter.

Test Plan:
- Reset, then read_a with address_a = 0x0000_0060, memory responding after 3 cycles with 0x0051_3093 -> pmem_read high from cycle 1, address 0x60; resp_a pulses in cycle 4 with rdata_a = 0x0051_3093; resp_b stays 0.
- After reset, read_a and write_b (address 0x100, wdata 0xDEAD_BEEF, wmask 4'b0011) asserted in the same cycle -> B is granted first with pmem_write, wmask 0011. A is served immediately after resp_b with no IDLE cycle, then the next tie goes to B again.
- Continuous read_a and read_b for 6 transactions -> grants alternate B, A, B, A, B, A; neither port is granted twice in a row.
- Drop read_a one cycle after grant -> pmem_read stays high until pmem_resp; resp_a still pulses once; state returns to IDLE.
- Assert rst_n low while in SERVE_B, then pulse pmem_resp after release -> all outputs 0 during reset; the stray pmem_resp produces no resp_a or resp_b; busy = 0.
- read_b and write_b both high at 0x200 -> pmem_write = 1, pmem_read = 0.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared types for the memory arbiter: FSM states, port identifiers and the latched command.
// Also holds the round-robin pick used both in IDLE and at completion edges.
package rv32i_types;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;
    localparam int ARB_MASK_W = ARB_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_A = 2'd1,
        SERVE_B = 2'd2
    } arb_state_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } arb_port_t;

    typedef struct packed {
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_DATA_W-1:0] wdata;
        logic [ARB_MASK_W-1:0] wmask;
        logic                  write;
    } mem_cmd_t;

    // On a tie the port that did not win last time goes next.
    function automatic arb_port_t arb_pick(input logic req_a, input logic req_b,
                                           input arb_port_t last);
        if (req_a && req_b) begin
            return (last == PORT_A) ? PORT_B : PORT_A;
        end else if (req_b) begin
            return PORT_B;
        end else begin
            return PORT_A;
        end
    endfunction

endpackage

// File: rtl/arb_cmd_reg.sv
// Command-capture register: holds the granted request's address, data, mask and type
// for the whole memory transaction so the pmem outputs never follow the requesters.
module arb_cmd_reg
    import rv32i_types::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     load_i,
    input  mem_cmd_t cmd_i,
    output mem_cmd_t cmd_o
);

    mem_cmd_t cmd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q <= '0;
        end else if (load_i) begin
            cmd_q <= cmd_i;
        end
    end

    assign cmd_o = cmd_q;

endmodule

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter sharing one memory port between instruction fetch (A, read-only)
// and the data stage (B, read/write). One transaction outstanding at a time.
module mem_arbiter
    import rv32i_types::*;
#(
    parameter int ADDR_WIDTH = ARB_ADDR_W,
    parameter int DATA_WIDTH = ARB_DATA_W,
    parameter int MASK_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  read_a,
    input  logic [ADDR_WIDTH-1:0] address_a,
    output logic                  resp_a,
    output logic [DATA_WIDTH-1:0] rdata_a,
    input  logic                  read_b,
    input  logic                  write_b,
    input  logic [ADDR_WIDTH-1:0] address_b,
    input  logic [DATA_WIDTH-1:0] wdata_b,
    input  logic [MASK_WIDTH-1:0] wmask_b,
    output logic                  resp_b,
    output logic [DATA_WIDTH-1:0] rdata_b,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [DATA_WIDTH-1:0] pmem_wdata,
    output logic [MASK_WIDTH-1:0] pmem_wmask,
    input  logic [DATA_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp,
    output logic                  busy
);

    arb_state_t state_q, state_d;
    arb_port_t  last_q, last_d;
    mem_cmd_t   cmd_d, cmd_q;
    logic       load;
    logic       arb_en;
    logic       req_a, req_b;
    arb_port_t  pick;
    logic [DATA_WIDTH-1:0] rdata_a_q, rdata_a_d;
    logic [DATA_WIDTH-1:0] rdata_b_q, rdata_b_d;

    assign req_a = read_a;
    assign req_b = read_b | write_b;
    assign pick  = arb_pick(req_a, req_b, last_q);

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        load      = 1'b0;
        arb_en    = 1'b0;
        cmd_d     = '0;
        resp_a    = 1'b0;
        resp_b    = 1'b0;
        rdata_a_d = rdata_a_q;
        rdata_b_d = rdata_b_q;

        case (state_q)
            IDLE: begin
                arb_en = 1'b1;
            end
            SERVE_A: begin
                if (pmem_resp) begin
                    resp_a    = 1'b1;
                    rdata_a_d = pmem_rdata;
                    arb_en    = 1'b1;
                    state_d   = IDLE;
                end
            end
            SERVE_B: begin
                if (pmem_resp) begin
                    resp_b    = 1'b1;
                    rdata_b_d = pmem_rdata;
                    arb_en    = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Completion edges re-arbitrate directly so a waiting port starts without an IDLE bubble;
        // last_q already names the finishing port, which hands a tie to the other one.
        if (arb_en && (req_a || req_b)) begin
            load   = 1'b1;
            last_d = pick;
            if (pick == PORT_A) begin
                state_d     = SERVE_A;
                cmd_d.addr  = address_a;
                cmd_d.wdata = '0;
                cmd_d.wmask = '0;
                cmd_d.write = 1'b0;
            end else begin
                state_d     = SERVE_B;
                cmd_d.addr  = address_b;
                cmd_d.wdata = wdata_b;
                cmd_d.wmask = wmask_b;
                cmd_d.write = write_b;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            last_q    <= PORT_A;
            rdata_a_q <= '0;
            rdata_b_q <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            rdata_a_q <= rdata_a_d;
            rdata_b_q <= rdata_b_d;
        end
    end

    arb_cmd_reg u_cmd_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (load),
        .cmd_i  (cmd_d),
        .cmd_o  (cmd_q)
    );

    assign busy         = (state_q != IDLE);
    assign pmem_read    = busy & ~cmd_q.write;
    assign pmem_write   = busy & cmd_q.write;
    assign pmem_address = cmd_q.addr;
    assign pmem_wdata   = cmd_q.wdata;
    assign pmem_wmask   = cmd_q.wmask;
    assign rdata_a      = rdata_a_d;
    assign rdata_b      = rdata_b_d;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a per-cycle vector table plus hand-written multi-cycle sequences.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        read_a, read_b, write_b, pmem_resp;
    logic [31:0] address_a, address_b, wdata_b, pmem_rdata;
    logic [3:0]  wmask_b;
    logic        resp_a, resp_b, pmem_read, pmem_write, busy;
    logic [31:0] rdata_a, rdata_b, pmem_address, pmem_wdata;
    logic [3:0]  pmem_wmask;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .read_a       (read_a),
        .address_a    (address_a),
        .resp_a       (resp_a),
        .rdata_a      (rdata_a),
        .read_b       (read_b),
        .write_b      (write_b),
        .address_b    (address_b),
        .wdata_b      (wdata_b),
        .wmask_b      (wmask_b),
        .resp_b       (resp_b),
        .rdata_b      (rdata_b),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_wmask   (pmem_wmask),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .busy         (busy)
    );

    typedef struct {
        string       name;
        logic        ra, rb, wb, presp;
        logic [31:0] prdata;
        logic        e_rd, e_wr, e_ra, e_rb, e_busy;
        logic [31:0] e_addr;
        logic [3:0]  e_mask;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string n, input logic ra, input logic rb, input logic wb,
                                input logic presp, input logic [31:0] prdata,
                                input logic e_rd, input logic e_wr, input logic e_ra,
                                input logic e_rb, input logic e_busy, input logic [31:0] e_addr,
                                input logic [3:0] e_mask, input logic [31:0] e_rdata);
        vec_t v;
        v.name = n; v.ra = ra; v.rb = rb; v.wb = wb; v.presp = presp; v.prdata = prdata;
        v.e_rd = e_rd; v.e_wr = e_wr; v.e_ra = e_ra; v.e_rb = e_rb; v.e_busy = e_busy;
        v.e_addr = e_addr; v.e_mask = e_mask; v.e_rdata = e_rdata;
        return v;
    endfunction

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic drive(input logic ra, input logic rb, input logic wb, input logic presp,
                         input logic [31:0] prdata);
        @(posedge clk);
        #1;
        read_a = ra; read_b = rb; write_b = wb; pmem_resp = presp; pmem_rdata = prdata;
        #1;
    endtask

    task automatic apply_vec(input vec_t v);
        drive(v.ra, v.rb, v.wb, v.presp, v.prdata);
        chk({v.name, ".pmem_read"},  {31'd0, pmem_read},  {31'd0, v.e_rd});
        chk({v.name, ".pmem_write"}, {31'd0, pmem_write}, {31'd0, v.e_wr});
        chk({v.name, ".resp_a"},     {31'd0, resp_a},     {31'd0, v.e_ra});
        chk({v.name, ".resp_b"},     {31'd0, resp_b},     {31'd0, v.e_rb});
        chk({v.name, ".busy"},       {31'd0, busy},       {31'd0, v.e_busy});
        if (v.e_rd || v.e_wr) begin
            chk({v.name, ".addr"}, pmem_address, v.e_addr);
            chk({v.name, ".mask"}, {28'd0, pmem_wmask}, {28'd0, v.e_mask});
        end
        if (v.e_wr) chk({v.name, ".wdata"}, pmem_wdata, 32'hDEAD_BEEF);
        if (v.e_ra) chk({v.name, ".rdata_a"}, rdata_a, v.e_rdata);
        if (v.e_rb) chk({v.name, ".rdata_b"}, rdata_b, v.e_rdata);
    endtask

    initial begin
        rst_n = 1'b0;
        read_a = 0; read_b = 0; write_b = 0; pmem_resp = 0; pmem_rdata = '0;
        address_a = 32'h0000_0060; address_b = 32'h0000_0100;
        wdata_b = 32'hDEAD_BEEF; wmask_b = 4'b0011;

        #1;
        chk("rst.pmem_read",  {31'd0, pmem_read},  32'd0);
        chk("rst.pmem_write", {31'd0, pmem_write}, 32'd0);
        chk("rst.busy",       {31'd0, busy},       32'd0);
        chk("rst.resp",       {30'd0, resp_a, resp_b}, 32'd0);
        chk("rst.rdata_a",    rdata_a, 32'd0);
        chk("rst.rdata_b",    rdata_b, 32'd0);
        chk("rst.addr",       pmem_address, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single port-A read, memory answers after three wait cycles.
        tbl.push_back(mk("t1_c0", 1,0,0,0,0,            0,0,0,0,0, 32'h0,   4'h0, 0));
        tbl.push_back(mk("t1_c1", 1,0,0,0,0,            1,0,0,0,1, 32'h60,  4'h0, 0));
        tbl.push_back(mk("t1_c2", 1,0,0,0,0,            1,0,0,0,1, 32'h60,  4'h0, 0));
        tbl.push_back(mk("t1_c3", 1,0,0,0,0,            1,0,0,0,1, 32'h60,  4'h0, 0));
        tbl.push_back(mk("t1_c4", 0,0,0,1,32'h0051_3093, 1,0,1,0,1, 32'h60,  4'h0, 32'h0051_3093));
        tbl.push_back(mk("t1_c5", 0,0,0,0,0,            0,0,0,0,0, 32'h0,   4'h0, 0));
        // First tie after reset goes to B, then A follows with no IDLE bubble.
        tbl.push_back(mk("t2_c0", 1,0,1,0,0,            0,0,0,0,0, 32'h0,   4'h0, 0));
        tbl.push_back(mk("t2_c1", 1,0,1,0,0,            0,1,0,0,1, 32'h100, 4'h3, 0));
        tbl.push_back(mk("t2_c2", 1,0,0,1,32'h1111_1111, 0,1,0,1,1, 32'h100, 4'h3, 32'h1111_1111));
        tbl.push_back(mk("t2_c3", 1,0,0,0,0,            1,0,0,0,1, 32'h60,  4'h0, 0));
        tbl.push_back(mk("t2_c4", 0,0,0,1,32'h2222_2222, 1,0,1,0,1, 32'h60,  4'h0, 32'h2222_2222));
        tbl.push_back(mk("t2_c5", 1,0,1,0,0,            0,0,0,0,0, 32'h0,   4'h0, 0));
        tbl.push_back(mk("t2_c6", 1,0,1,0,0,            0,1,0,0,1, 32'h100, 4'h3, 0));
        tbl.push_back(mk("t2_c7", 1,0,0,1,32'h3333_3333, 0,1,0,1,1, 32'h100, 4'h3, 32'h3333_3333));
        tbl.push_back(mk("t2_c8", 1,0,0,0,0,            1,0,0,0,1, 32'h60,  4'h0, 0));
        tbl.push_back(mk("t2_c9", 0,0,0,1,32'h4444_4444, 1,0,1,0,1, 32'h60,  4'h0, 32'h4444_4444));
        // Both ports held continuously with a one-cycle memory: grants must alternate B,A,B,A,B,A.
        tbl.push_back(mk("t3_c0", 1,1,0,0,0,            0,0,0,0,0, 32'h0,   4'h0, 0));
        for (int k = 1; k <= 6; k++) begin
            logic hold;
            hold = (k != 6);
            if (k % 2 == 1)
                tbl.push_back(mk($sformatf("t3_b%0d", k), hold, hold, 0, 1, 32'hC0 + k,
                                 1,0,0,1,1, 32'h100, 4'h3, 32'hC0 + k));
            else
                tbl.push_back(mk($sformatf("t3_a%0d", k), hold, hold, 0, 1, 32'hC0 + k,
                                 1,0,1,0,1, 32'h60, 4'h0, 32'hC0 + k));
        end
        tbl.push_back(mk("t3_end", 0,0,0,0,0,           0,0,0,0,0, 32'h0,   4'h0, 0));

        foreach (tbl[i]) apply_vec(tbl[i]);

        // Requester drops read_a right after grant: the read still runs to completion.
        drive(1,0,0,0,0);
        drive(0,0,0,0,0);
        chk("drop.rd_c1", {31'd0, pmem_read}, 32'd1);
        drive(0,0,0,0,0);
        chk("drop.rd_c2", {31'd0, pmem_read}, 32'd1);
        drive(0,0,0,1,32'h5555_0001);
        chk("drop.resp_a", {31'd0, resp_a}, 32'd1);
        chk("drop.rdata_a", rdata_a, 32'h5555_0001);
        drive(0,0,0,0,0);
        chk("drop.busy", {31'd0, busy}, 32'd0);
        chk("drop.resp_a_once", {31'd0, resp_a}, 32'd0);

        // Asynchronous reset while serving B, then a stray pmem_resp after release.
        drive(0,1,0,0,0);
        drive(0,1,0,0,0);
        chk("rstmid.busy_pre", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        pmem_resp = 1'b1;
        #1;
        chk("rstmid.busy", {31'd0, busy}, 32'd0);
        chk("rstmid.cmd", {30'd0, pmem_read, pmem_write}, 32'd0);
        chk("rstmid.resp", {30'd0, resp_a, resp_b}, 32'd0);
        chk("rstmid.rdata_b", rdata_b, 32'd0);
        read_b = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(0,0,0,1,32'h6666_6666);
        chk("stray.resp", {30'd0, resp_a, resp_b}, 32'd0);
        chk("stray.busy", {31'd0, busy}, 32'd0);
        drive(0,0,0,0,0);
        chk("stray.busy2", {31'd0, busy}, 32'd0);

        // read_b and write_b together count as a write.
        address_b = 32'h0000_0200;
        drive(0,1,1,0,0);
        drive(0,1,1,0,0);
        chk("rdwr.write", {31'd0, pmem_write}, 32'd1);
        chk("rdwr.read",  {31'd0, pmem_read},  32'd0);
        chk("rdwr.addr",  pmem_address, 32'h200);
        chk("rdwr.wdata", pmem_wdata, 32'hDEAD_BEEF);
        drive(0,0,0,1,0);
        chk("rdwr.resp_b", {31'd0, resp_b}, 32'd1);
        drive(0,0,0,0,0);
        chk("rdwr.write_off", {31'd0, pmem_write}, 32'd0);
        chk("rdwr.busy", {31'd0, busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
